// File: rtl/uart_tx_fifo_if.sv
// Producer-side bundle for uart_tx_fifo: byte handshake, per-frame framing config
// and the serial/status outputs.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 3
);
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_byte;
  logic [3:0]        data_bits;
  logic [1:0]        parity;
  logic              stop_bits;
  logic [15:0]       baud_div;
  logic              tx_serial;
  logic              tx_busy;
  logic              tx_done;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output tx_valid, tx_byte, data_bits, parity, stop_bits, baud_div,
    input  tx_ready, tx_serial, tx_busy, tx_done, fifo_count
  );

  modport slave (
    input  tx_valid, tx_byte, data_bits, parity, stop_bits, baud_div,
    output tx_ready, tx_serial, tx_busy, tx_done, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; framing (data bits, parity, stops, divisor)
// is captured per frame when the byte is popped.
module uart_tx_fifo #(
  parameter int unsigned SYS_CLOCK     = 50000000,
  parameter int unsigned UART_BAUDRATE = 115200,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic          i_SysClock,
  input  logic          i_ResetN,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned DEF_DIV = (SYS_CLOCK + UART_BAUDRATE / 2) / UART_BAUDRATE - 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DIV_W-1:0]  cyc_q, div_q;
  logic [3:0]        bit_idx_q, nbits_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_en_q, par_bit_q, stop2_q, stop_idx_q;
  logic              serial_q, busy_q, done_q;

  logic              full_c, empty_c, wr_c, bit_end_c, stop_end_c, pop_c;
  logic [3:0]        nbits_c;
  logic [DIV_W-1:0]  div_c;
  logic [DATA_W-1:0] head_c, mask_c;
  logic              par_en_c, par_bit_c, line_c;

  // A full FIFO refuses writes even when a pop lands on the same edge.
  assign full_c     = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign wr_c       = bus.tx_valid && !full_c;
  assign bit_end_c  = (cyc_q == div_q);
  assign stop_end_c = (state_q == STOP) && bit_end_c && (stop_idx_q == stop2_q);
  assign pop_c      = !empty_c && ((state_q == IDLE) || stop_end_c);

  always_comb begin
    nbits_c = bus.data_bits;
    if (bus.data_bits < 4'd5)              nbits_c = 4'd5;
    else if (bus.data_bits > 4'(DATA_W))   nbits_c = 4'(DATA_W);
  end

  assign div_c     = (bus.baud_div == '0) ? DIV_W'(DEF_DIV) : bus.baud_div;
  assign head_c    = mem_q[rd_ptr_q];
  assign mask_c    = ~({DATA_W{1'b1}} << nbits_c);
  assign par_en_c  = (bus.parity == 2'b01) || (bus.parity == 2'b10);
  assign par_bit_c = (^(head_c & mask_c)) ^ (bus.parity == 2'b10);

  // Line value for the current state; registered one cycle later into serial_q.
  always_comb begin
    line_c = 1'b1;
    case (state_q)
      START:   line_c = 1'b0;
      DATA:    line_c = shift_q[0];
      PARITY:  line_c = par_bit_q;
      default: line_c = 1'b1;
    endcase
  end

  always_ff @(posedge i_SysClock) begin
    if (wr_c) mem_q[wr_ptr_q] <= bus.tx_byte;
  end

  always_ff @(posedge i_SysClock) begin
    if (!i_ResetN) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      cyc_q      <= '0;
      div_q      <= '0;
      bit_idx_q  <= '0;
      nbits_q    <= '0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b1;
    end else begin
      serial_q <= line_c;
      busy_q   <= (state_q != IDLE);
      done_q   <= (state_q == IDLE) && empty_c;

      if (wr_c)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(wr_c) - CNT_W'(pop_c);

      // Framing config is captured only here, so mid-frame changes wait for the next pop.
      if (pop_c) begin
        shift_q   <= head_c;
        nbits_q   <= nbits_c;
        par_en_q  <= par_en_c;
        par_bit_q <= par_bit_c;
        stop2_q   <= bus.stop_bits;
        div_q     <= div_c;
      end

      case (state_q)
        IDLE: begin
          if (pop_c) begin
            state_q <= START;
            cyc_q   <= '0;
          end
        end
        START: begin
          if (bit_end_c) begin
            cyc_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            cyc_q <= cyc_q + DIV_W'(1);
          end
        end
        DATA: begin
          if (bit_end_c) begin
            cyc_q   <= '0;
            shift_q <= shift_q >> 1;
            if (bit_idx_q == nbits_q - 4'd1) begin
              state_q    <= par_en_q ? PARITY : STOP;
              stop_idx_q <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
            end
          end else begin
            cyc_q <= cyc_q + DIV_W'(1);
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            cyc_q      <= '0;
            stop_idx_q <= 1'b0;
            state_q    <= STOP;
          end else begin
            cyc_q <= cyc_q + DIV_W'(1);
          end
        end
        STOP: begin
          if (bit_end_c) begin
            cyc_q <= '0;
            if (stop_idx_q == stop2_q) state_q <= pop_c ? START : IDLE;
            else                       stop_idx_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + DIV_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_ready   = !full_c;
  assign bus.tx_serial  = serial_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, latency, FIFO back-pressure,
// config sampling at pop and mid-frame reset.
module tb_uart_tx_fifo;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  uart_tx_fifo_if #(.DATA_W(8), .CNT_W(3)) bus ();

  uart_tx_fifo #(
    .SYS_CLOCK(50000000), .UART_BAUDRATE(115200), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .i_SysClock(clk),
    .i_ResetN  (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.tx_valid = 1'b1;
    bus.tx_byte  = b;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic st,
                         input logic [15:0] div);
    bus.data_bits = nb;
    bus.parity    = par;
    bus.stop_bits = st;
    bus.baud_div  = div;
  endtask

  // Samples first and last cycle of every bit; vector bit 0 is the start bit.
  task automatic expect_frame(input string tag, input int len, input logic [15:0] exp,
                              input int per, input bit b2b, output int waited);
    logic [15:0] fa, la;
    bit          busy_ok;
    int          w;
    fa = '0; la = '0; busy_ok = 1'b1; w = 0;
    if (b2b) begin
      chk({tag, "_nogap"}, 32'(bus.tx_serial), 32'd0);
    end else begin
      while (bus.tx_serial !== 1'b0 && w < 20000) begin
        @(negedge clk);
        w++;
      end
      chk({tag, "_start"}, 32'(bus.tx_serial), 32'd0);
    end
    for (int k = 0; k < len; k++) begin
      fa[4'(k)] = bus.tx_serial;
      if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
      repeat (per - 1) @(negedge clk);
      la[4'(k)] = bus.tx_serial;
      if (bus.tx_busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_bits_first"}, 32'(fa), 32'(exp));
    chk({tag, "_bits_last"},  32'(la), 32'(exp));
    chk({tag, "_busy"},       32'(busy_ok), 32'd1);
    waited = w;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_done"}, 32'(bus.tx_done), 32'd1);
    chk({tag, "_idle"}, 32'(bus.tx_busy), 32'd0);
  endtask

  initial begin
    int          w;
    int          bad;
    logic [7:0]  b [6];

    checks = 0; errors = 0;
    bus.tx_valid = 1'b0;
    bus.tx_byte  = '0;
    set_cfg(4'd8, 2'b00, 1'b0, 16'd0);
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h3C; b[3] = 8'h81; b[4] = 8'hF0; b[5] = 8'h5A;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_serial", 32'(bus.tx_serial), 32'd1);
    chk("rst_busy",   32'(bus.tx_busy),   32'd0);
    chk("rst_done",   32'(bus.tx_done),   32'd1);
    chk("rst_ready",  32'(bus.tx_ready),  32'd1);
    chk("rst_count",  32'(bus.fifo_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 at the default divisor (434 cycles per bit)
    push(8'hA5);
    chk("lat_count_w", 32'(bus.fifo_count), 32'd1);
    chk("lat_line_w",  32'(bus.tx_serial),  32'd1);
    @(negedge clk);
    chk("lat_count_pop", 32'(bus.fifo_count), 32'd0);
    chk("lat_line_pop",  32'(bus.tx_serial),  32'd1);
    chk("lat_busy_pop",  32'(bus.tx_busy),    32'd0);
    expect_frame("8n1", 10, 16'h034A, 434, 1'b0, w);
    chk("8n1_latency", 32'(w), 32'd1);
    expect_idle("8n1");

    // 7E2, div 9
    set_cfg(4'd7, 2'b01, 1'b1, 16'd9);
    push(8'h41);
    expect_frame("7e2", 11, 16'h0682, 10, 1'b0, w);
    expect_idle("7e2");

    // 5O1, div 3
    set_cfg(4'd5, 2'b10, 1'b0, 16'd3);
    push(8'h1F);
    expect_frame("5o1", 8, 16'h00BE, 4, 1'b0, w);
    expect_idle("5o1");

    // data_bits above DATA_W clamps to 8: 0x81, even parity, 2 stops, div 1
    set_cfg(4'd15, 2'b01, 1'b1, 16'd1);
    push(8'h81);
    expect_frame("clamp_hi", 12, 16'h0D02, 2, 1'b0, w);
    expect_idle("clamp_hi");

    // data_bits below 5 clamps to 5: 0xE3 sends only 1,1,0,0,0
    set_cfg(4'd2, 2'b00, 1'b0, 16'd1);
    push(8'hE3);
    expect_frame("clamp_lo", 7, 16'h0046, 2, 1'b0, w);
    expect_idle("clamp_lo");

    // FIFO back-pressure with six bytes held on the bus, 8N1 div 3
    set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
    fork
      begin : producer
        int  n;
        bit  pend;
        bit  seen;
        n = 0; seen = 1'b0;
        bus.tx_valid = 1'b1;
        bus.tx_byte  = b[0];
        pend = bus.tx_ready;
        for (int c = 0; c < 200 && n < 6; c++) begin
          @(negedge clk);
          if (pend) begin
            n++;
            if (n < 6) bus.tx_byte = b[n];
            else       bus.tx_valid = 1'b0;
          end
          if (c == 10) begin
            chk("full_accepted", 32'(n), 32'd5);
            chk("full_ready",    32'(bus.tx_ready), 32'd0);
            chk("full_count",    32'(bus.fifo_count), 32'd4);
          end
          if (n == 5 && !seen && bus.tx_ready === 1'b1) begin
            seen = 1'b1;
            chk("ready_ret_count", 32'(bus.fifo_count), 32'd3);
            chk("ready_ret_line",  32'(bus.tx_serial),  32'd1);
          end
          pend = bus.tx_ready && (n < 6);
        end
        chk("full_all_accepted", 32'(n), 32'd6);
      end
      begin : consumer
        for (int i = 0; i < 6; i++)
          expect_frame($sformatf("fifo%0d", i), 10, 16'({1'b1, b[i], 1'b0}), 4, i != 0, w);
      end
    join
    expect_idle("fifo");
    chk("fifo_empty", 32'(bus.fifo_count), 32'd0);

    // Parity switched to odd during frame A's data; only frame B picks it up
    set_cfg(4'd8, 2'b00, 1'b0, 16'd3);
    push(8'h33);
    push(8'h07);
    fork
      begin
        repeat (6) @(negedge clk);
        bus.parity = 2'b10;
      end
      begin
        expect_frame("cfg_a", 10, 16'({1'b1, 8'h33, 1'b0}), 4, 1'b0, w);
        expect_frame("cfg_b", 11, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 4, 1'b1, w);
      end
    join
    expect_idle("cfg");
    bus.parity = 2'b00;

    // Reset mid-frame with two bytes queued
    push(8'h55);
    push(8'h66);
    push(8'h77);
    repeat (8) @(negedge clk);
    chk("prerst_count", 32'(bus.fifo_count), 32'd2);
    chk("prerst_busy",  32'(bus.tx_busy),    32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_serial", 32'(bus.tx_serial),  32'd1);
    chk("midrst_count",  32'(bus.fifo_count), 32'd0);
    chk("midrst_done",   32'(bus.tx_done),    32'd1);
    chk("midrst_busy",   32'(bus.tx_busy),    32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (bus.tx_serial !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
    end
    chk("postrst_quiet", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
